mem_stage: RTL and testbench

Memory-access pipeline stage between execute and writeback. It passes ALU results and store operands through to writeback with one registered cycle. For loads it issues a doubleword read to the data cache and waits for the response. It then aligns and sign/zero-extends the returned data into `out_mdata`. Stores are not performed here; writeback commits them.

---
 rtl/mem_pkg.sv | 70 +++++++
 rtl/mem_stage_if.sv | 30 +++
 rtl/load_extend.sv | 39 +++
 rtl/mem_stage.sv | 203 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared types and helpers for the memory-access stage: FSM state
//            encoding, load size encoding, load opcode name constants, and
//            opcode-name decode / misalignment helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int NAME_W = 96;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'd0,
    SZ_HALF   = 2'd1,
    SZ_WORD   = 2'd2,
    SZ_DOUBLE = 2'd3
  } load_size_e;

  typedef struct packed {
    logic       is_load;
    load_size_e size;
    logic       is_signed;
  } load_dec_t;

  // Opcode names are right-justified ASCII, zero-padded on the left.
  localparam logic [NAME_W-1:0] OP_LB  = {80'd0, "lb"};
  localparam logic [NAME_W-1:0] OP_LBU = {72'd0, "lbu"};
  localparam logic [NAME_W-1:0] OP_LH  = {80'd0, "lh"};
  localparam logic [NAME_W-1:0] OP_LHU = {72'd0, "lhu"};
  localparam logic [NAME_W-1:0] OP_LW  = {80'd0, "lw"};
  localparam logic [NAME_W-1:0] OP_LWU = {72'd0, "lwu"};
  localparam logic [NAME_W-1:0] OP_LD  = {80'd0, "ld"};

  function automatic load_dec_t decode_load(input logic [NAME_W-1:0] name);
    load_dec_t d;
    d = '{is_load: 1'b0, size: SZ_DOUBLE, is_signed: 1'b0};
    case (name)
      OP_LB:   d = '{is_load: 1'b1, size: SZ_BYTE,   is_signed: 1'b1};
      OP_LBU:  d = '{is_load: 1'b1, size: SZ_BYTE,   is_signed: 1'b0};
      OP_LH:   d = '{is_load: 1'b1, size: SZ_HALF,   is_signed: 1'b1};
      OP_LHU:  d = '{is_load: 1'b1, size: SZ_HALF,   is_signed: 1'b0};
      OP_LW:   d = '{is_load: 1'b1, size: SZ_WORD,   is_signed: 1'b1};
      OP_LWU:  d = '{is_load: 1'b1, size: SZ_WORD,   is_signed: 1'b0};
      OP_LD:   d = '{is_load: 1'b1, size: SZ_DOUBLE, is_signed: 1'b0};
      default: d = '{is_load: 1'b0, size: SZ_DOUBLE, is_signed: 1'b0};
    endcase
    return d;
  endfunction

  function automatic logic is_misaligned(input load_size_e size, input logic [2:0] offset);
    logic mis;
    case (size)
      SZ_HALF:   mis = offset[0];
      SZ_WORD:   mis = |offset[1:0];
      SZ_DOUBLE: mis = |offset;
      default:   mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_if
// Purpose  : Data-cache read channel between the memory stage and the cache.
// Ports    : out_dc_req / out_dc_addr  stage -> cache read request
//            in_dc_ack                 cache accepted the request
//            in_dc_resp_valid/_data    read response doubleword
//            modport master = stage side, modport slave = cache side
// Revision : 1.0 - initial release
// ============================================================================
interface mem_stage_if #(
  parameter int ADDRESS_WIDTH = 64
);
  logic                     out_dc_req;
  logic [ADDRESS_WIDTH-1:0] out_dc_addr;
  logic                     in_dc_ack;
  logic                     in_dc_resp_valid;
  logic [63:0]              in_dc_resp_data;

  modport master (
    output out_dc_req, out_dc_addr,
    input  in_dc_ack, in_dc_resp_valid, in_dc_resp_data
  );

  modport slave (
    input  out_dc_req, out_dc_addr,
    output in_dc_ack, in_dc_resp_valid, in_dc_resp_data
  );
endinterface
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// Module   : load_extend
// Purpose  : Combinational load data alignment and sign/zero extension.
//            The doubleword is shifted right by the byte offset (zeros fill
//            from the top) and the low byte/half/word is extended.
// Ports    : resp_data  in  raw doubleword from the cache
//            offset     in  byte offset within the doubleword
//            size       in  load size
//            is_signed  in  sign-extend when set
//            ext_data   out aligned, extended result
// Revision : 1.0 - initial release
// ============================================================================
module load_extend
  import mem_pkg::*;
(
  input  logic [63:0] resp_data,
  input  logic [2:0]  offset,
  input  load_size_e  size,
  input  logic        is_signed,
  output logic [63:0] ext_data
);

  logic [63:0] shifted;

  assign shifted = resp_data >> {offset, 3'b000};

  always_comb begin
    ext_data = shifted;
    case (size)
      SZ_BYTE: ext_data = {{56{is_signed & shifted[7]}},  shifted[7:0]};
      SZ_HALF: ext_data = {{48{is_signed & shifted[15]}}, shifted[15:0]};
      SZ_WORD: ext_data = {{32{is_signed & shifted[31]}}, shifted[31:0]};
      default: ext_data = shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access pipeline stage. Registers execute results through
//            to writeback in one cycle; loads issue a doubleword cache read,
//            wait for the response and deliver extended data in out_mdata.
//            Optional macro MEM_MISALIGN_CHECK_EN: misaligned loads skip the
//            cache and complete in one cycle with out_misaligned=1.
// Ports    : clk, reset (sync, active-high)
//            in_*        instruction from execute
//            out_busy    stage busy with a load, execute must hold
//            dc          data-cache read channel (mem_stage_if.master)
//            out_*       registered instruction to writeback
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage
  import mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH          = 64,
  parameter int REGISTER_WIDTH         = 64,
  parameter int REGISTERNO_WIDTH       = 5,
  parameter int INSTRUCTION_NAME_WIDTH = 96
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_enable,
  input  logic [INSTRUCTION_NAME_WIDTH-1:0] in_opcode_name,
  input  logic [REGISTER_WIDTH-1:0]         in_alu_result,
  input  logic [ADDRESS_WIDTH-1:0]          in_phy_addr,
  input  logic [REGISTER_WIDTH-1:0]         in_rs2_value,
  input  logic [REGISTERNO_WIDTH-1:0]       in_rd_regno,
  input  logic                              in_update_rd_bool,
  input  logic                              in_branch_taken_bool,
  output logic                              out_busy,
  mem_stage_if.master                       dc,
  output logic                              out_enable,
  output logic [INSTRUCTION_NAME_WIDTH-1:0] out_opcode_name,
  output logic [REGISTER_WIDTH-1:0]         out_alu_result,
  output logic [ADDRESS_WIDTH-1:0]          out_phy_addr,
  output logic [REGISTER_WIDTH-1:0]         out_rs2_value,
  output logic [REGISTERNO_WIDTH-1:0]       out_rd_regno,
  output logic                              out_update_rd_bool,
  output logic                              out_branch_taken_bool,
  output logic [REGISTER_WIDTH-1:0]         out_mdata,
  output logic                              out_mm_load_bool,
  output logic                              out_misaligned
);

  mem_state_e                        state_q, state_d;
  load_size_e                        ld_size_q, ld_size_d;
  logic                              ld_signed_q, ld_signed_d;
  logic                              enable_q, enable_d;
  logic [INSTRUCTION_NAME_WIDTH-1:0] opcode_q, opcode_d;
  logic [REGISTER_WIDTH-1:0]         alu_q, alu_d;
  logic [ADDRESS_WIDTH-1:0]          addr_q, addr_d;
  logic [REGISTER_WIDTH-1:0]         rs2_q, rs2_d;
  logic [REGISTERNO_WIDTH-1:0]       rd_q, rd_d;
  logic                              upd_q, upd_d;
  logic                              br_q, br_d;
  logic [REGISTER_WIDTH-1:0]         mdata_q, mdata_d;
  logic                              mm_load_q, mm_load_d;
  logic                              mis_q, mis_d;

  load_dec_t   dec;
  logic [63:0] ext_data;

  assign dec = decode_load(in_opcode_name);

  // Extension always works on the captured address/size so the response can
  // be consumed in either REQ or WAIT.
  load_extend u_load_extend (
    .resp_data (dc.in_dc_resp_data),
    .offset    (addr_q[2:0]),
    .size      (ld_size_q),
    .is_signed (ld_signed_q),
    .ext_data  (ext_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ld_size_q   <= SZ_BYTE;
      ld_signed_q <= 1'b0;
      enable_q    <= 1'b0;
      opcode_q    <= '0;
      alu_q       <= '0;
      addr_q      <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      upd_q       <= 1'b0;
      br_q        <= 1'b0;
      mdata_q     <= '0;
      mm_load_q   <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_size_q   <= ld_size_d;
      ld_signed_q <= ld_signed_d;
      enable_q    <= enable_d;
      opcode_q    <= opcode_d;
      alu_q       <= alu_d;
      addr_q      <= addr_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      upd_q       <= upd_d;
      br_q        <= br_d;
      mdata_q     <= mdata_d;
      mm_load_q   <= mm_load_d;
      mis_q       <= mis_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ld_size_d   = ld_size_q;
    ld_signed_d = ld_signed_q;
    enable_d    = 1'b0;
    opcode_d    = opcode_q;
    alu_d       = alu_q;
    addr_d      = addr_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    upd_d       = upd_q;
    br_d        = br_q;
    mdata_d     = mdata_q;
    mm_load_d   = mm_load_q;
    mis_d       = mis_q;

    case (state_q)
      ST_IDLE: begin
        if (in_enable) begin
          opcode_d = in_opcode_name;
          alu_d    = in_alu_result;
          addr_d   = in_phy_addr;
          rs2_d    = in_rs2_value;
          rd_d     = in_rd_regno;
          upd_d    = in_update_rd_bool;
          br_d     = in_branch_taken_bool;
          mis_d    = 1'b0;
          if (dec.is_load) begin
            ld_size_d   = dec.size;
            ld_signed_d = dec.is_signed;
`ifdef MEM_MISALIGN_CHECK_EN
            if (is_misaligned(dec.size, in_phy_addr[2:0])) begin
              // Faulting load: no cache access, rd write suppressed.
              enable_d  = 1'b1;
              mis_d     = 1'b1;
              upd_d     = 1'b0;
              mdata_d   = '0;
              mm_load_d = 1'b1;
            end else
`endif
            begin
              state_d = ST_REQ;
            end
          end else begin
            enable_d  = 1'b1;
            mdata_d   = '0;
            mm_load_d = 1'b0;
          end
        end
      end
      ST_REQ: begin
        if (dc.in_dc_ack) begin
          if (dc.in_dc_resp_valid) begin
            enable_d  = 1'b1;
            mdata_d   = ext_data;
            mm_load_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (dc.in_dc_resp_valid) begin
          enable_d  = 1'b1;
          mdata_d   = ext_data;
          mm_load_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_busy              = (state_q != ST_IDLE);
  assign dc.out_dc_req         = (state_q == ST_REQ);
  assign dc.out_dc_addr        = {addr_q[ADDRESS_WIDTH-1:3], 3'b000};
  assign out_enable            = enable_q;
  assign out_opcode_name       = opcode_q;
  assign out_alu_result        = alu_q;
  assign out_phy_addr          = addr_q;
  assign out_rs2_value         = rs2_q;
  assign out_rd_regno          = rd_q;
  assign out_update_rd_bool    = upd_q;
  assign out_branch_taken_bool = br_q;
  assign out_mdata             = mdata_q;
  assign out_mm_load_bool      = mm_load_q;
  assign out_misaligned        = mis_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage. Directed stimulus pushes the
//            expected writeback record into a queue; a monitor pops and
//            compares on every out_enable pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_enable;
  logic [95:0] in_opcode_name;
  logic [63:0] in_alu_result, in_phy_addr, in_rs2_value;
  logic [4:0]  in_rd_regno;
  logic        in_update_rd_bool, in_branch_taken_bool;
  logic        out_busy, out_enable;
  logic [95:0] out_opcode_name;
  logic [63:0] out_alu_result, out_phy_addr, out_rs2_value, out_mdata;
  logic [4:0]  out_rd_regno;
  logic        out_update_rd_bool, out_branch_taken_bool, out_mm_load_bool, out_misaligned;

  mem_stage_if #(.ADDRESS_WIDTH(64)) dc_if ();

  mem_stage dut (
    .clk(clk), .reset(reset), .in_enable(in_enable), .in_opcode_name(in_opcode_name),
    .in_alu_result(in_alu_result), .in_phy_addr(in_phy_addr), .in_rs2_value(in_rs2_value),
    .in_rd_regno(in_rd_regno), .in_update_rd_bool(in_update_rd_bool),
    .in_branch_taken_bool(in_branch_taken_bool), .out_busy(out_busy), .dc(dc_if),
    .out_enable(out_enable), .out_opcode_name(out_opcode_name),
    .out_alu_result(out_alu_result), .out_phy_addr(out_phy_addr),
    .out_rs2_value(out_rs2_value), .out_rd_regno(out_rd_regno),
    .out_update_rd_bool(out_update_rd_bool), .out_branch_taken_bool(out_branch_taken_bool),
    .out_mdata(out_mdata), .out_mm_load_bool(out_mm_load_bool), .out_misaligned(out_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] mdata;
    logic [63:0] alu;
    logic [4:0]  rd;
    logic        upd;
    logic        mm;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  localparam logic [95:0] OP_ADD = {72'd0, "add"};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
  endtask

  // Monitor: every writeback pulse must match the oldest expected record.
  always @(negedge clk) begin
    if (!reset && out_enable) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_enable", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wb_mdata",     out_mdata,                  e.mdata);
        check("wb_alu",       out_alu_result,             e.alu);
        check("wb_rd",        {59'd0, out_rd_regno},      {59'd0, e.rd});
        check("wb_update_rd", {63'd0, out_update_rd_bool}, {63'd0, e.upd});
        check("wb_mm_load",   {63'd0, out_mm_load_bool},  {63'd0, e.mm});
        check("wb_misalign",  {63'd0, out_misaligned},    {63'd0, e.mis});
      end
    end
  end

  // Called at a negedge; returns at the negedge after the result registers.
  task automatic issue_alu(input logic [63:0] alu, input logic [4:0] rd);
    exp_q.push_back('{mdata: 64'd0, alu: alu, rd: rd, upd: 1'b1, mm: 1'b0, mis: 1'b0});
    in_enable = 1'b1; in_opcode_name = OP_ADD; in_alu_result = alu;
    in_rd_regno = rd; in_update_rd_bool = 1'b1; in_phy_addr = 64'd0;
    @(posedge clk); #1 in_enable = 1'b0;
    @(negedge clk);
    check("alu_busy", {63'd0, out_busy}, 64'd0);
  endtask

  // Load with ack after ack_dly extra REQ cycles and response resp_dly
  // cycles after ack (0 = same cycle). Returns at the completion negedge.
  task automatic do_load(input logic [95:0] op, input logic [63:0] addr,
                         input logic [63:0] data, input int ack_dly,
                         input int resp_dly, input logic [63:0] exp_mdata,
                         input logic [4:0] rd);
    exp_q.push_back('{mdata: exp_mdata, alu: addr, rd: rd, upd: 1'b1, mm: 1'b1, mis: 1'b0});
    in_enable = 1'b1; in_opcode_name = op; in_phy_addr = addr; in_alu_result = addr;
    in_rd_regno = rd; in_update_rd_bool = 1'b1;
    dc_if.in_dc_resp_data = data;
    @(posedge clk); #1 in_enable = 1'b0;
    @(negedge clk);
    check("ld_busy",    {63'd0, out_busy},          64'd1);
    check("ld_dc_req",  {63'd0, dc_if.out_dc_req},  64'd1);
    check("ld_dc_addr", dc_if.out_dc_addr,          addr & ~64'h7);
    for (int i = 0; i < ack_dly; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("ld_req_hold", {63'd0, dc_if.out_dc_req}, 64'd1);
    end
    dc_if.in_dc_ack = 1'b1;
    dc_if.in_dc_resp_valid = (resp_dly == 0);
    @(posedge clk); #1 dc_if.in_dc_ack = 1'b0; dc_if.in_dc_resp_valid = 1'b0;
    if (resp_dly > 0) begin
      for (int i = 1; i < resp_dly; i++) begin
        @(posedge clk); #1;
      end
      @(negedge clk);
      check("ld_wait_busy", {63'd0, out_busy}, 64'd1);
      dc_if.in_dc_resp_valid = 1'b1;
      @(posedge clk); #1 dc_if.in_dc_resp_valid = 1'b0;
    end
    @(negedge clk);
    check("ld_done_busy", {63'd0, out_busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_enable = 1'b0; in_opcode_name = '0; in_alu_result = '0;
    in_phy_addr = '0; in_rs2_value = '0; in_rd_regno = '0;
    in_update_rd_bool = 1'b0; in_branch_taken_bool = 1'b0;
    dc_if.in_dc_ack = 1'b0; dc_if.in_dc_resp_valid = 1'b0; dc_if.in_dc_resp_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_enable",  {63'd0, out_enable},       64'd0);
    check("rst_busy",    {63'd0, out_busy},         64'd0);
    check("rst_dc_req",  {63'd0, dc_if.out_dc_req}, 64'd0);
    check("rst_mdata",   out_mdata,                 64'd0);
    check("rst_alu",     out_alu_result,            64'd0);
    reset = 1'b0;

    issue_alu(64'h2A, 5'd5);
    do_load(OP_LD,  64'h1000, 64'h1122334455667788, 1, 2, 64'h1122334455667788, 5'd6);
    do_load(OP_LB,  64'h1003, 64'h0000000080000000, 0, 0, 64'hFFFFFFFFFFFFFF80, 5'd7);
    do_load(OP_LBU, 64'h1003, 64'h0000000080000000, 0, 0, 64'h0000000000000080, 5'd8);
    do_load(OP_LW,  64'h1004, 64'h89ABCDEF00000000, 0, 1, 64'hFFFFFFFF89ABCDEF, 5'd9);
    do_load(OP_LWU, 64'h1004, 64'h89ABCDEF00000000, 2, 0, 64'h0000000089ABCDEF, 5'd10);
    do_load(OP_LH,  64'h1006, 64'h8001000000000000, 0, 0, 64'hFFFFFFFFFFFF8001, 5'd11);
    // Back-to-back: issued during the cycle the load's out_enable is high.
    issue_alu(64'h55, 5'd12);
    do_load(OP_LHU, 64'h1006, 64'h8001000000000000, 0, 0, 64'h0000000000008001, 5'd13);

`ifdef MEM_MISALIGN_CHECK_EN
    exp_q.push_back('{mdata: 64'd0, alu: 64'h1002, rd: 5'd14, upd: 1'b0, mm: 1'b1, mis: 1'b1});
    in_enable = 1'b1; in_opcode_name = OP_LW; in_phy_addr = 64'h1002;
    in_alu_result = 64'h1002; in_rd_regno = 5'd14; in_update_rd_bool = 1'b1;
    @(posedge clk); #1 in_enable = 1'b0;
    @(negedge clk);
    check("mis_dc_req", {63'd0, dc_if.out_dc_req}, 64'd0);
    check("mis_busy",   {63'd0, out_busy},         64'd0);
`else
    do_load(OP_LW,  64'h1002, 64'h000089ABCDEF0000, 0, 0, 64'hFFFFFFFF89ABCDEF, 5'd14);
`endif

    // Reset while waiting for the response; late response must be ignored.
    in_enable = 1'b1; in_opcode_name = OP_LD; in_phy_addr = 64'h2000; in_alu_result = 64'h2000;
    @(posedge clk); #1 in_enable = 1'b0; dc_if.in_dc_ack = 1'b1;
    @(posedge clk); #1 dc_if.in_dc_ack = 1'b0;
    @(negedge clk);
    check("wait_busy", {63'd0, out_busy}, 64'd1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; dc_if.in_dc_resp_valid = 1'b1;
    @(negedge clk);
    check("mid_rst_busy",    {63'd0, out_busy},         64'd0);
    check("mid_rst_dc_req",  {63'd0, dc_if.out_dc_req}, 64'd0);
    check("mid_rst_mm_load", {63'd0, out_mm_load_bool}, 64'd0);
    check("mid_rst_addr",    out_phy_addr,              64'd0);
    check("mid_rst_mdata",   out_mdata,                 64'd0);
    @(posedge clk); #1 dc_if.in_dc_resp_valid = 1'b0;
    @(negedge clk);
    check("late_resp_enable", {63'd0, out_enable}, 64'd0);
    check("late_resp_busy",   {63'd0, out_busy},   64'd0);
    issue_alu(64'h77, 5'd3);

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
